// File: rtl/pc_unit.sv
// Program-counter unit at the head of the IF stage.
// Holds the PC, chooses the next PC from halt, jump, branch, stall or sequential
// sources, runs the debug run/step/halt FSM, and keeps saturating activity counters.
module pc_unit #(
    parameter int unsigned      LEN         = 32,
    parameter int unsigned      INSTR_BYTES = 4,
    parameter logic [LEN-1:0]   RESET_ADDR  = '0,
    parameter int unsigned      CNT_LEN     = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_enable,
    input  logic               i_step_mode,
    input  logic               i_step,
    input  logic               i_stall,
    input  logic               i_branch_taken,
    input  logic [LEN-1:0]     i_branch_addr,
    input  logic               i_jump,
    input  logic [LEN-1:0]     i_jump_addr,
    input  logic               i_halt,
    output logic [LEN-1:0]     o_pc,
    output logic [LEN-1:0]     o_pc_next_seq,
    output logic               o_halted,
    output logic               o_running,
    output logic [CNT_LEN-1:0] o_cycle_cnt,
    output logic [CNT_LEN-1:0] o_fetch_cnt
);

    localparam int unsigned      ALIGN_BITS = $clog2(INSTR_BYTES);
    localparam logic [LEN-1:0]   ALIGN_MASK = {LEN{1'b1}} << ALIGN_BITS;
    localparam logic [LEN-1:0]   PC_INC     = LEN'(INSTR_BYTES);
    localparam logic [CNT_LEN-1:0] CNT_MAX  = '1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] STEP   = 2'd2;
    localparam logic [1:0] HALTED = 2'd3;

    logic [1:0]         state;
    logic [1:0]         state_next;
    logic               step_prev;
    logic               step_edge;
    logic               adv;
    logic [LEN-1:0]     pc_next;
    logic [CNT_LEN-1:0] cycle_next;
    logic [CNT_LEN-1:0] fetch_next;

    // Sequential fetch address, wraps modulo 2^LEN
    assign o_pc_next_seq = o_pc + PC_INC;

    // Next-state, next-PC and counter logic
    always_comb begin
        state_next = state;
        pc_next    = o_pc;
        cycle_next = o_cycle_cnt;
        fetch_next = o_fetch_cnt;
        step_edge  = i_step & ~step_prev;
        adv        = (state == RUN) || ((state == STEP) && step_edge);

        case (state)
            IDLE: begin
                if (i_enable) begin
                    state_next = i_step_mode ? STEP : RUN;
                end
            end
            RUN, STEP: begin
                if (adv && i_halt) begin
                    state_next = HALTED;
                end else if (!i_enable) begin
                    state_next = IDLE;
                end else begin
                    state_next = i_step_mode ? STEP : RUN;
                end
            end
            HALTED: begin
                state_next = HALTED;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (adv) begin
            if (o_cycle_cnt != CNT_MAX) begin
                cycle_next = o_cycle_cnt + CNT_LEN'(1);
            end
            // Redirects win over stall so a flush is never lost
            if (!i_halt && (i_jump || i_branch_taken || !i_stall)) begin
                if (i_jump) begin
                    pc_next = i_jump_addr & ALIGN_MASK;
                end else if (i_branch_taken) begin
                    pc_next = i_branch_addr & ALIGN_MASK;
                end else begin
                    pc_next = o_pc_next_seq;
                end
                if (o_fetch_cnt != CNT_MAX) begin
                    fetch_next = o_fetch_cnt + CNT_LEN'(1);
                end
            end
        end
    end

    // State, PC, counter and status registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            step_prev   <= 1'b0;
            o_pc        <= RESET_ADDR;
            o_cycle_cnt <= '0;
            o_fetch_cnt <= '0;
            o_halted    <= 1'b0;
            o_running   <= 1'b0;
        end else begin
            state       <= state_next;
            step_prev   <= i_step;
            o_pc        <= pc_next;
            o_cycle_cnt <= cycle_next;
            o_fetch_cnt <= fetch_next;
            o_halted    <= (state_next == HALTED);
            o_running   <= (state_next == RUN);
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus randomized stimulus
// against a behavioural model of the PC unit.
module tb_pc_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, enable, step_mode, step, stall, branch_taken, jump, halt;
    logic [31:0] branch_addr, jump_addr;

    logic [31:0] pc, pc_next_seq, cycle_cnt, fetch_cnt;
    logic        halted, running;
    logic [7:0]  pc_w, seq_w;
    logic [31:0] cyc_w, fetch_w;
    logic        halted_w, running_w;
    logic [31:0] pc_s, seq_s;
    logic [2:0]  cyc_s, fetch_s;
    logic        halted_s, running_s;

    int errors = 0;
    int checks = 0;

    // Behavioural model
    bit     m_active, m_stepmode, m_halted, m_prev_step;
    longint m_pc, m_cyc, m_fetch;
    localparam longint PC_MOD  = 64'h1_0000_0000;
    localparam longint CNT_TOP = 64'hFFFF_FFFF;

    pc_unit dut (
        .clk(clk), .reset(reset), .i_enable(enable), .i_step_mode(step_mode),
        .i_step(step), .i_stall(stall), .i_branch_taken(branch_taken),
        .i_branch_addr(branch_addr), .i_jump(jump), .i_jump_addr(jump_addr),
        .i_halt(halt), .o_pc(pc), .o_pc_next_seq(pc_next_seq), .o_halted(halted),
        .o_running(running), .o_cycle_cnt(cycle_cnt), .o_fetch_cnt(fetch_cnt)
    );

    pc_unit #(.LEN(8), .RESET_ADDR(8'hFC)) dut_w (
        .clk(clk), .reset(reset), .i_enable(enable), .i_step_mode(step_mode),
        .i_step(step), .i_stall(stall), .i_branch_taken(branch_taken),
        .i_branch_addr(branch_addr[7:0]), .i_jump(jump), .i_jump_addr(jump_addr[7:0]),
        .i_halt(halt), .o_pc(pc_w), .o_pc_next_seq(seq_w), .o_halted(halted_w),
        .o_running(running_w), .o_cycle_cnt(cyc_w), .o_fetch_cnt(fetch_w)
    );

    pc_unit #(.CNT_LEN(3)) dut_s (
        .clk(clk), .reset(reset), .i_enable(enable), .i_step_mode(step_mode),
        .i_step(step), .i_stall(stall), .i_branch_taken(branch_taken),
        .i_branch_addr(branch_addr), .i_jump(jump), .i_jump_addr(jump_addr),
        .i_halt(halt), .o_pc(pc_s), .o_pc_next_seq(seq_s), .o_halted(halted_s),
        .o_running(running_s), .o_cycle_cnt(cyc_s), .o_fetch_cnt(fetch_s)
    );

    // Advance the model with the current inputs, then clock the DUT and settle
    task automatic tick();
        bit edge_s, adv;
        edge_s = step && !m_prev_step;
        adv    = m_active && !m_halted && (!m_stepmode || edge_s);
        if (reset) begin
            m_active = 0; m_stepmode = 0; m_halted = 0; m_prev_step = 0;
            m_pc = 0; m_cyc = 0; m_fetch = 0;
        end else begin
            if (adv) begin
                if (m_cyc < CNT_TOP) m_cyc++;
                if (!halt && (jump || branch_taken || !stall) && m_fetch < CNT_TOP) m_fetch++;
                if (halt)              m_pc = m_pc;
                else if (jump)         m_pc = longint'(jump_addr) - longint'(jump_addr % 4);
                else if (branch_taken) m_pc = longint'(branch_addr) - longint'(branch_addr % 4);
                else if (!stall)       m_pc = (m_pc + 4) % PC_MOD;
            end
            if (adv && halt) begin
                m_halted = 1;
            end else if (!m_halted) begin
                if (m_active && !enable) m_active = 0;
                else if (enable) begin m_active = 1; m_stepmode = step_mode; end
            end
            m_prev_step = step;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        enable = 0; step_mode = 0; step = 0; stall = 0; branch_taken = 0;
        jump = 0; halt = 0; branch_addr = '0; jump_addr = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1; tick(); tick();
        reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h0); end
        checks++; if (pc_next_seq !== 32'h4) begin errors++; $display("FAIL reset_seq: got %h expected %h", pc_next_seq, 32'h4); end
        checks++; if (halted !== 1'b0 || running !== 1'b0) begin errors++; $display("FAIL reset_flags: got %b%b expected 00", halted, running); end
        checks++; if (cycle_cnt !== 32'd0 || fetch_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", cycle_cnt, fetch_cnt); end
    endtask

    task automatic test_run();
        logic [31:0] exp_pc [6] = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd16, 32'd20};
        do_reset();
        enable = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if (pc !== exp_pc[i]) begin errors++; $display("FAIL run_pc[%0d]: got %h expected %h", i, pc, exp_pc[i]); end
        end
        checks++; if (fetch_cnt !== 32'd5) begin errors++; $display("FAIL run_fetch: got %0d expected 5", fetch_cnt); end
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL run_running: got %b expected 1", running); end
    endtask

    task automatic run_to(input longint target);
        int n = 0;
        do_reset();
        enable = 1;
        while (m_pc != target && n < 40) begin tick(); n++; end
        checks++; if (pc !== 32'(target)) begin errors++; $display("FAIL run_to: got %h expected %h", pc, 32'(target)); end
    endtask

    task automatic test_stall_branch();
        logic [31:0] f0;
        run_to(64'h10);
        f0 = fetch_cnt;
        stall = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (pc !== 32'h10) begin errors++; $display("FAIL stall_hold[%0d]: got %h expected %h", i, pc, 32'h10); end
        end
        checks++; if (fetch_cnt !== f0) begin errors++; $display("FAIL stall_fetch: got %0d expected %0d", fetch_cnt, f0); end
        branch_taken = 1; branch_addr = 32'h43;
        tick();
        checks++; if (pc !== 32'h40) begin errors++; $display("FAIL stall_branch: got %h expected %h", pc, 32'h40); end
        checks++; if (fetch_cnt !== f0 + 32'd1) begin errors++; $display("FAIL branch_fetch: got %0d expected %0d", fetch_cnt, f0 + 32'd1); end
        stall = 0; branch_taken = 0;
    endtask

    task automatic test_jump_branch();
        do_reset();
        enable = 1; tick();
        jump = 1; jump_addr = 32'h200; branch_taken = 1; branch_addr = 32'h100;
        tick();
        checks++; if (pc !== 32'h200) begin errors++; $display("FAIL jump_beats_branch: got %h expected %h", pc, 32'h200); end
        checks++; if (pc_next_seq !== 32'h204) begin errors++; $display("FAIL jump_seq: got %h expected %h", pc_next_seq, 32'h204); end
        branch_taken = 0; jump_addr = 32'h1237;
        tick();
        checks++; if (pc !== 32'h1234) begin errors++; $display("FAIL jump_align: got %h expected %h", pc, 32'h1234); end
        jump = 0;
    endtask

    task automatic test_halt();
        run_to(64'h24);
        halt = 1;
        tick();
        halt = 0;
        checks++; if (pc !== 32'h24) begin errors++; $display("FAIL halt_pc: got %h expected %h", pc, 32'h24); end
        checks++; if (halted !== 1'b1 || running !== 1'b0) begin errors++; $display("FAIL halt_flags: got %b%b expected 10", halted, running); end
        for (int i = 0; i < 8; i++) begin
            enable = i[0]; step_mode = i[1]; step = (i % 3 == 0);
            tick();
            checks++; if (pc !== 32'h24 || halted !== 1'b1) begin errors++; $display("FAIL halt_sticky[%0d]: got %h/%b expected %h/1", i, pc, halted, 32'h24); end
        end
        reset = 1; tick(); reset = 0;
        checks++; if (pc !== 32'h0 || halted !== 1'b0) begin errors++; $display("FAIL halt_reset: got %h/%b expected 0/0", pc, halted); end
    endtask

    task automatic test_step();
        do_reset();
        enable = 1; step_mode = 1;
        tick();
        step = 1;
        for (int i = 0; i < 4; i++) tick();
        checks++; if (pc !== 32'h4) begin errors++; $display("FAIL step_first: got %h expected %h", pc, 32'h4); end
        step = 0; tick();
        step = 1; tick();
        checks++; if (pc !== 32'h8) begin errors++; $display("FAIL step_pc: got %h expected %h", pc, 32'h8); end
        checks++; if (cycle_cnt !== 32'd2) begin errors++; $display("FAIL step_cycles: got %0d expected 2", cycle_cnt); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL step_running: got %b expected 0", running); end
        step = 0;
    endtask

    task automatic test_wrap_saturate();
        do_reset();
        enable = 1;
        tick(); tick();
        checks++; if (pc_w !== 8'h00) begin errors++; $display("FAIL wrap_pc: got %h expected %h", pc_w, 8'h00); end
        checks++; if (seq_w !== 8'h04) begin errors++; $display("FAIL wrap_seq: got %h expected %h", seq_w, 8'h04); end
        for (int i = 0; i < 10; i++) tick();
        checks++; if (cyc_s !== 3'd7 || fetch_s !== 3'd7) begin errors++; $display("FAIL saturate: got %0d/%0d expected 7/7", cyc_s, fetch_s); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            reset        = ($urandom_range(0, 79) == 0);
            enable       = ($urandom_range(0, 7) != 0);
            step_mode    = ($urandom_range(0, 3) == 0);
            step         = $urandom_range(0, 1) == 1;
            stall        = ($urandom_range(0, 3) == 0);
            branch_taken = ($urandom_range(0, 5) == 0);
            jump         = ($urandom_range(0, 7) == 0);
            halt         = ($urandom_range(0, 49) == 0);
            branch_addr  = $urandom;
            jump_addr    = $urandom;
            tick();
            checks++; if (pc !== 32'(m_pc)) begin errors++; $display("FAIL rnd_pc[%0d]: got %h expected %h", i, pc, 32'(m_pc)); end
            checks++; if (pc_next_seq !== 32'((m_pc + 4) % PC_MOD)) begin errors++; $display("FAIL rnd_seq[%0d]: got %h expected %h", i, pc_next_seq, 32'((m_pc + 4) % PC_MOD)); end
            checks++; if (cycle_cnt !== 32'(m_cyc) || fetch_cnt !== 32'(m_fetch)) begin errors++; $display("FAIL rnd_cnt[%0d]: got %0d/%0d expected %0d/%0d", i, cycle_cnt, fetch_cnt, m_cyc, m_fetch); end
            checks++; if (halted !== m_halted) begin errors++; $display("FAIL rnd_halted[%0d]: got %b expected %b", i, halted, m_halted); end
            checks++; if (running !== (m_active && !m_stepmode && !m_halted)) begin errors++; $display("FAIL rnd_running[%0d]: got %b expected %b", i, running, m_active && !m_stepmode && !m_halted); end
        end
        reset = 0;
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        test_reset();
        test_run();
        test_stall_branch();
        test_jump_branch();
        test_halt();
        test_step();
        test_wrap_saturate();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the pipelined MIPS core. Generalises the plain PC register.
- Adds a registered next-PC select for sequential, branch and jump targets, plus a stall hold.
- Adds halt detection and a debug run/step control FSM for the UART debug unit.
- Adds saturating cycle and retired-fetch counters.
- Sits at the head of the IF stage, feeding instruction memory and the IF/ID latch.

Parameters:
- LEN, 32: PC and target address width in bits.
- INSTR_BYTES, 4: PC increment in bytes; power of two, at least 1.
- RESET_ADDR, 0: PC value loaded on reset. Must be a multiple of INSTR_BYTES.
- CNT_LEN, 32: width of the cycle and fetch counters.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- i_enable, input, 1: debug unit permits execution.
- i_step_mode, input, 1: 0 = continuous run, 1 = single-step.
- i_step, input, 1: step request level; an internal rising-edge detect turns it into a one-cycle step.
- i_stall, input, 1: hazard unit requests PC hold.
- i_branch_taken, input, 1: branch resolved taken.
- i_branch_addr, input, LEN: branch target.
- i_jump, input, 1: jump or jump-register redirect.
- i_jump_addr, input, LEN: jump target.
- i_halt, input, 1: HALT instruction decoded.
- o_pc, output, LEN: current PC (registered).
- o_pc_next_seq, output, LEN: o_pc + INSTR_BYTES, combinational, modulo 2^LEN.
- o_halted, output, 1: high while the FSM is in HALTED.
- o_running, output, 1: high while the FSM is in RUN.
- o_cycle_cnt, output, CNT_LEN: count of advance cycles.
- o_fetch_cnt, output, CNT_LEN: count of PC updates.

Behaviour:
- Reset: on reset=1 at a clock edge, the following are forced.
  - o_pc = RESET_ADDR.
  - FSM = IDLE.
  - Both counters = 0.
  - Step edge-detect register = 0.
  - o_halted = 0, o_running = 0.
- Reset mid-operation (any state) aborts immediately with the same values.
- FSM states: IDLE, RUN, STEP, HALTED.
  - IDLE -> RUN when i_enable=1 and i_step_mode=0.
  - IDLE -> STEP when i_enable=1 and i_step_mode=1.
  - RUN -> IDLE when i_enable=0.
  - STEP -> IDLE when i_enable=0.
  - RUN <-> STEP follow i_step_mode while i_enable=1.
  - RUN or STEP -> HALTED when i_halt=1 in an advance cycle.
  - HALTED is left only by reset.
- adv (advance cycle) is true when state==RUN, or when state==STEP and a step edge is detected.
  - The step edge is i_step=1 with the previous sampled i_step=0.
  - Exactly one advance per rising edge of i_step.
- PC update on an adv cycle, in priority order:
  1. i_halt: PC holds.
  2. i_jump: PC <= i_jump_addr with its low log2(INSTR_BYTES) bits cleared.
  3. i_branch_taken: PC <= i_branch_addr, aligned the same way.
  4. i_stall: PC holds.
  5. Otherwise: PC <= o_pc_next_seq.
- Redirects override stall (the flush has priority).
- A non-adv cycle holds the PC regardless of the other inputs.
- Counters:
  - o_cycle_cnt increments on every adv cycle.
  - o_fetch_cnt increments on adv cycles where the PC changes source: jump, branch or sequential. It does not increment on halt or stall holds.
  - Both counters saturate at 2^CNT_LEN-1; no wrap.
- Arithmetic: the sequential PC wraps modulo 2^LEN. From 2^LEN-INSTR_BYTES the next PC is 0.
- Latency: a redirect presented in cycle N is visible on o_pc after edge N+1. o_pc_next_seq tracks o_pc combinationally.

Test Plan:
- Reset/run: reset 2 cycles, then i_enable=1 and mode=0 for 5 cycles.
  - Required: o_pc = 0,4,8,12,16,20; o_fetch_cnt=5; o_running=1.
- Stall vs branch: at pc=0x10, i_stall=1 for 2 cycles, then i_stall=1 with i_branch_taken=1 and addr=0x43.
  - Required: o_pc holds at 0x10 for 2 cycles, then becomes 0x40. o_fetch_cnt is unchanged by the stalls.
- Jump beats branch: i_jump=1 with addr 0x200 and i_branch_taken=1 with addr 0x100, same cycle.
  - Required: o_pc=0x200.
- Halt: i_halt=1 at pc=0x24.
  - Required: o_pc stays 0x24, o_halted=1.
  - Required: i_enable toggling and step pulses change nothing until reset, after which o_pc=0.
- Step mode: mode=1, i_step held high 4 cycles, then low, then high.
  - Required: exactly 2 PC advances (0 -> 4 -> 8); o_cycle_cnt=2.
- Wrap/saturate: LEN=8, start at pc=0xFC and run 1 cycle; separately CNT_LEN=3 and run 10 cycles.
  - Required: o_pc=0x00 in the first case.
  - Required: counters stick at 7 in the second case.
